// File: rtl/tdc_onehot_encoder_pipe_if.sv
// Sample/result bundle for the TDC one-hot encoder.
// The producer side (edge detector plus timestamp assembler glue) uses the master modport.
// The encoder uses the slave modport.
interface tdc_onehot_encoder_pipe_if #(
    parameter int unsigned WIDTH = 175,
    parameter int unsigned IDX_W = 8,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] one_hot;
    logic             cnt_clear;
    logic             out_valid;
    logic [IDX_W-1:0] index;
    logic             zero_hot;
    logic             multi_hot;
    logic [CNT_W-1:0] zero_cnt;
    logic [CNT_W-1:0] multi_cnt;

    modport master (
        output in_valid, one_hot, cnt_clear,
        input  out_valid, index, zero_hot, multi_hot, zero_cnt, multi_cnt
    );

    modport slave (
        input  in_valid, one_hot, cnt_clear,
        output out_valid, index, zero_hot, multi_hot, zero_cnt, multi_cnt
    );
endinterface

// File: rtl/tdc_onehot_encoder_pipe.sv
// Pipelined one-hot -> binary encoder for the TDC fine-time path.
// Stage 1 registers the sample, stage 2 encodes fixed-size groups, and stage 3 merges the groups.
// Stage 3 also registers the index and the error flags.
// Saturating error counters follow the registered flags.
// The interface instance must be built with the same WIDTH/IDX_W/CNT_W as this module.
module tdc_onehot_encoder_pipe #(
    parameter int unsigned WIDTH     = 175,
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned GROUP     = 16,
    parameter string       DIRECTION = "LSB0",
    parameter int unsigned CNT_W     = 16
) (
    input logic                      clk,
    input logic                      rst_n,
    tdc_onehot_encoder_pipe_if.slave bus
);
    localparam int unsigned NGROUP = (WIDTH + GROUP - 1) / GROUP;
    localparam int unsigned PAD_W  = NGROUP * GROUP;
    localparam int unsigned LOC_W  = (GROUP < 2) ? 1 : $clog2(GROUP);
    localparam bit          MSB0   = (DIRECTION == "MSB0");

    if ((64'd1 << IDX_W) < 64'(WIDTH)) begin : g_err_idx_w
        $error("IDX_W too small for WIDTH");
    end
    if (GROUP < 2) begin : g_err_group
        $error("GROUP must be at least 2");
    end
    if (DIRECTION != "LSB0" && DIRECTION != "MSB0") begin : g_err_dir
        $error("DIRECTION must be LSB0 or MSB0");
    end

    // MSB0 is a pure wire reversal, so everything downstream only ever sees LSB0 numbering.
    logic [WIDTH-1:0] hot_map;
    assign hot_map = MSB0 ? {<<{bus.one_hot}} : bus.one_hot;

    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_hot_q;

    // Stage 1: capture the direction-mapped sample and its valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_hot_q   <= '0;
        end else begin
            s1_valid_q <= bus.in_valid;
            s1_hot_q   <= hot_map;
        end
    end

    // Zero-extend so the last (partial) group needs no bounds special case.
    logic [PAD_W-1:0] hot_pad;
    assign hot_pad = PAD_W'(s1_hot_q);

    logic [LOC_W-1:0]  grp_idx [NGROUP];
    logic [NGROUP-1:0] grp_any;
    logic [NGROUP-1:0] grp_two;

    // Stage 2 logic: per group, OR the local positions and flag any-set / two-or-more-set.
    always_comb begin
        for (int unsigned g = 0; g < NGROUP; g++) begin
            logic [LOC_W-1:0] acc;
            logic             seen;
            logic             two;
            acc  = '0;
            seen = 1'b0;
            two  = 1'b0;
            for (int unsigned j = 0; j < GROUP; j++) begin
                if (hot_pad[g * GROUP + j]) begin
                    acc  = acc | LOC_W'(j);
                    two  = two | seen;
                    seen = 1'b1;
                end
            end
            grp_idx[g] = acc;
            grp_any[g] = seen;
            grp_two[g] = two;
        end
    end

    logic              s2_valid_q;
    logic [LOC_W-1:0]  s2_idx_q [NGROUP];
    logic [NGROUP-1:0] s2_any_q;
    logic [NGROUP-1:0] s2_two_q;

    // Stage 2: register the per-group results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_idx_q   <= '{default: '0};
            s2_any_q   <= '0;
            s2_two_q   <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_idx_q   <= grp_idx;
            s2_any_q   <= grp_any;
            s2_two_q   <= grp_two;
        end
    end

    logic [IDX_W-1:0] idx_c;
    logic             zero_c;
    logic             multi_c;

    // Stage 3 logic: offset and OR-merge active groups; two active groups also means multi-hot.
    always_comb begin
        logic act_seen;
        idx_c    = '0;
        multi_c  = |s2_two_q;
        act_seen = 1'b0;
        for (int unsigned g = 0; g < NGROUP; g++) begin
            if (s2_any_q[g]) begin
                idx_c    = idx_c | (IDX_W'(g * GROUP) + IDX_W'(s2_idx_q[g]));
                multi_c  = multi_c | act_seen;
                act_seen = 1'b1;
            end
        end
        zero_c = ~act_seen;
    end

    logic             out_valid_q;
    logic [IDX_W-1:0] index_q;
    logic             zero_hot_q;
    logic             multi_hot_q;

    // Stage 3: register outputs; index and flags hold across invalid cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            index_q     <= '0;
            zero_hot_q  <= 1'b0;
            multi_hot_q <= 1'b0;
        end else begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                index_q     <= idx_c;
                zero_hot_q  <= zero_c;
                multi_hot_q <= multi_c;
            end
        end
    end

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] zero_cnt_q;
    logic [CNT_W-1:0] multi_cnt_q;

    // Error counters count presented (valid) flagged outputs; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_cnt_q  <= '0;
            multi_cnt_q <= '0;
        end else if (bus.cnt_clear) begin
            zero_cnt_q  <= '0;
            multi_cnt_q <= '0;
        end else begin
            if (out_valid_q && zero_hot_q && zero_cnt_q != CNT_MAX) begin
                zero_cnt_q <= zero_cnt_q + 1'b1;
            end
            if (out_valid_q && multi_hot_q && multi_cnt_q != CNT_MAX) begin
                multi_cnt_q <= multi_cnt_q + 1'b1;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.index     = index_q;
    assign bus.zero_hot  = zero_hot_q;
    assign bus.multi_hot = multi_hot_q;
    assign bus.zero_cnt  = zero_cnt_q;
    assign bus.multi_cnt = multi_cnt_q;
endmodule
